// File: rtl/coffee_dispense_fsm.sv
// Coffee dispense sequencer. It latches a drink code and walks ingredients 0..4.
// For each ingredient it takes the time in seconds from an external lookup.
// It then opens that ingredient's valve for time*TICK_DIV clock cycles.
// Every output comes from a register, so no input reaches an output combinationally.
module coffee_dispense_fsm #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] coffee_sel,
    input  logic       cancel,
    input  logic [2:0] ingredient_time,
    output logic [2:0] coffee_type,
    output logic [2:0] ingredient_sel,
    output logic [4:0] valve,
    output logic [2:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    // A single-cycle tick (TICK_DIV=1) still needs a 1-bit prescaler to keep widths legal
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(TICK_DIV - 1);
    localparam logic [2:0]    LAST    = 3'd4;

    typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, DONE} state_t;

    state_t        r_state;
    logic [2:0]    r_coffee_type;
    logic [2:0]    r_ing_sel;
    logic [2:0]    r_remaining;
    logic [4:0]    r_valve;
    logic          r_done;
    logic          r_aborted;
    logic [PW-1:0] r_psc;
    logic          w_sel_ok;

    assign w_sel_ok       = (coffee_sel >= 3'd1) && (coffee_sel <= 3'd4);
    assign coffee_type    = r_coffee_type;
    assign ingredient_sel = r_ing_sel;
    assign valve          = r_valve;
    assign remaining      = r_remaining;
    assign busy           = (r_state != IDLE);
    assign done           = r_done;
    assign aborted        = r_aborted;

    // Brew sequencer: state, ingredient walk, prescaler and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_coffee_type <= 3'd0;
            r_ing_sel     <= 3'd0;
            r_remaining   <= 3'd0;
            r_valve       <= 5'd0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_psc         <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (cancel && r_state != IDLE) begin
                // Cancel overrides every other transition outside IDLE
                r_state     <= IDLE;
                r_valve     <= 5'd0;
                r_remaining <= 3'd0;
                r_psc       <= '0;
                r_aborted   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && w_sel_ok) begin
                            r_coffee_type <= coffee_sel;
                            r_ing_sel     <= 3'd0;
                            r_state       <= LOAD;
                        end
                    end
                    LOAD: begin
                        r_remaining <= ingredient_time;
                        if (ingredient_time != 3'd0) begin
                            r_state <= DISPENSE;
                            r_psc   <= '0;
                            r_valve <= 5'(5'd1 << r_ing_sel);
                        end else if (r_ing_sel == LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Zero-time ingredient: move straight to the next lookup
                            r_ing_sel <= r_ing_sel + 3'd1;
                        end
                    end
                    DISPENSE: begin
                        if (r_psc == PSC_MAX) begin
                            r_psc <= '0;
                            if (r_remaining <= 3'd1) begin
                                // Last second elapsed; the guard also keeps remaining from underflowing
                                r_remaining <= 3'd0;
                                r_valve     <= 5'd0;
                                if (r_ing_sel < LAST) begin
                                    r_ing_sel <= r_ing_sel + 3'd1;
                                    r_state   <= LOAD;
                                end else begin
                                    r_state <= DONE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_remaining <= r_remaining - 3'd1;
                            end
                        end else begin
                            r_psc <= r_psc + PW'(1);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coffee_dispense_fsm.sv
// Bench for coffee_dispense_fsm with TICK_DIV=4 and a modelled time-per-coffee lookup.
// Expected valve runs, done and abort events are queued when a brew is launched.
// A monitor checks them against the observed outputs.
module tb_coffee_dispense_fsm;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] coffee_sel;
    logic       cancel;
    logic [2:0] ingredient_time;
    logic [2:0] coffee_type;
    logic [2:0] ingredient_sel;
    logic [4:0] valve;
    logic [2:0] remaining;
    logic       busy;
    logic       done;
    logic       aborted;

    coffee_dispense_fsm #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .coffee_sel(coffee_sel),
        .cancel(cancel), .ingredient_time(ingredient_time),
        .coffee_type(coffee_type), .ingredient_sel(ingredient_sel),
        .valve(valve), .remaining(remaining), .busy(busy), .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Lookup model: seconds per ingredient (water, coffee, milk, chocolate, sugar)
    int tbl [5][5] = '{
        '{0, 0, 0, 0, 0},
        '{3, 4, 1, 1, 2},   // expreso
        '{3, 1, 4, 0, 1},   // with milk
        '{2, 2, 3, 0, 1},   // capuccino
        '{2, 2, 2, 3, 2}    // mocaccino
    };
    bit skip2 = 1'b0;

    always_comb begin
        ingredient_time = 3'd0;
        if (coffee_type <= 3'd4 && ingredient_sel <= 3'd4 && !(skip2 && ingredient_sel == 3'd2))
            ingredient_time = 3'(tbl[coffee_type][ingredient_sel]);
    end

    // kind 0: valve run (a=gap cycles before, b=valve, c=length); 1: done (a=offset); 2: abort (a=offset)
    typedef struct {int kind; int a; int b; int c;} exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int start_edge = 0;

    task automatic chk_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // Queue the event sequence a brew should produce, relative to its start-sampling edge
    task automatic expect_brew(input int ct, input bit sk, input int cancel_off);
        int off = 0;
        int gap = 0;
        for (int i = 0; i < 5; i++) begin
            int t;
            int st;
            int len;
            t = (sk && i == 2) ? 0 : tbl[ct][i];
            gap++;
            if (t == 0) begin
                off++;
                continue;
            end
            st  = off + 1;
            len = t * TD;
            if (cancel_off > 0 && cancel_off < st + len) begin
                q.push_back('{0, gap, 1 << i, cancel_off - st});
                q.push_back('{2, cancel_off, 0, 0});
                return;
            end
            q.push_back('{0, gap, 1 << i, len});
            gap = 0;
            off = st + len;
        end
        q.push_back('{1, off, 0, 0});
    endtask

    // Monitor state
    bit   in_run;
    int   run_len, run_gap, gap, busy_cnt, m_off;
    int   run_valve;
    exp_t e;

    task automatic pop_exp(output exp_t r, output bit ok);
        chk_eq("sb_avail", int'(q.size() > 0), 1);
        ok = (q.size() > 0);
        r  = '{-1, 0, 0, 0};
        if (ok) r = q.pop_front();
    endtask

    task automatic close_run();
        exp_t r;
        bit   ok;
        pop_exp(r, ok);
        if (ok) begin
            chk_eq("run_kind", 0, r.kind);
            chk_eq("run_gap", run_gap, r.a);
            chk_eq("run_valve", run_valve, r.b);
            chk_eq("run_len", run_len, r.c);
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_run   = 1'b0;
            run_len  = 0;
            gap      = 0;
            busy_cnt = 0;
        end else begin
            bit ok;
            m_off = edge_n - start_edge;
            if (busy) busy_cnt++; else busy_cnt = 0;
            if (valve != 5'd0) begin
                if (in_run && int'(valve) == run_valve) run_len++;
                else begin
                    if (in_run) close_run();
                    in_run    = 1'b1;
                    run_valve = int'(valve);
                    run_len   = 1;
                    run_gap   = gap;
                    gap       = 0;
                end
            end else begin
                if (in_run) close_run();
                in_run = 1'b0;
                if (busy && !done) gap++;
                if (!busy) gap = 0;
            end
            if (done) begin
                pop_exp(e, ok);
                if (ok) begin
                    chk_eq("done_kind", 1, e.kind);
                    chk_eq("done_off", m_off, e.a);
                    chk_eq("busy_len", busy_cnt, e.a + 1);
                end
            end
            if (aborted) begin
                pop_exp(e, ok);
                if (ok) begin
                    chk_eq("abort_kind", 2, e.kind);
                    chk_eq("abort_off", m_off, e.a);
                end
            end
        end
    end

    function automatic int cur_off();
        return edge_n - start_edge;
    endfunction

    // Pulse start for one cycle from a falling edge; returns at offset 0 of the brew
    task automatic do_start(input logic [2:0] sel);
        start      = 1'b1;
        coffee_sel = sel;
        start_edge = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_off(input int k);
        for (int i = 0; i < 400 && cur_off() < k; i++) @(negedge clk);
        chk_eq("wait_off", cur_off(), k);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        chk_eq("idle_reached", int'(busy), 0);
        @(negedge clk);
    endtask

    task automatic brew(input int ct);
        expect_brew(ct, skip2, 0);
        do_start(3'(ct));
        chk_eq("busy_on", int'(busy), 1);
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; coffee_sel = 3'd0; cancel = 1'b0;
        #1;
        chk_eq("rst_state", {coffee_type, ingredient_sel, remaining, valve, busy, done, aborted}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Expreso with a mid-brew start carrying another code
        expect_brew(1, 1'b0, 0);
        do_start(3'd1);
        chk_eq("busy_on", int'(busy), 1);
        wait_off(5);
        chk_eq("remaining_at5", int'(remaining), 2);
        chk_eq("sel_at5", int'(ingredient_sel), 0);
        wait_off(20);
        start = 1'b1; coffee_sel = 3'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk_eq("ctype_hold", int'(coffee_type), 1);
        wait_idle();

        brew(4);   // mocaccino
        brew(3);   // capuccino: chocolate time 0 skips naturally

        // Forced skip of ingredient 2
        skip2 = 1'b1;
        brew(1);
        skip2 = 1'b0;

        // Cancel during coffee dispense, sampled at offset 20
        expect_brew(1, 1'b0, 20);
        do_start(3'd1);
        wait_off(19);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk_eq("cancel_valve", int'(valve), 0);
        chk_eq("cancel_busy", int'(busy), 0);
        @(negedge clk);

        // Illegal selects and cancel while idle
        start = 1'b1; coffee_sel = 3'd0;
        @(negedge clk);
        chk_eq("sel0_busy", int'(busy), 0);
        coffee_sel = 3'd6;
        @(negedge clk);
        start = 1'b0;
        chk_eq("sel6_busy", int'(busy), 0);
        chk_eq("sel6_ctype", int'(coffee_type), 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk_eq("idle_cancel", int'({busy, aborted}), 0);

        // Asynchronous reset mid-dispense
        expect_brew(1, 1'b0, 0);
        do_start(3'd1);
        wait_off(20);
        chk_eq("pre_rst_valve", int'(valve), 2);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst_outs", {coffee_type, ingredient_sel, remaining, valve, busy, done, aborted}, 0);
        q.delete();
        #4 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_eq("post_rst_idle", int'({busy, done}), 0);
        brew(4);

        chk_eq("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
